// File: rtl/dmem_mmio_responder.sv
// ----------------------------------------------------------------------------
// dmem_mmio_responder
//
// Responder for the core's external data-memory port. Two regions are
// decoded from the byte address (addr[1:0] ignored, word accesses only):
//   - word RAM at byte addresses 0 .. RAM_WORDS*4-1
//   - a 16-byte MMIO window at MMIO_BASE:
//       +0x0 TXDATA  write pushes wr_data[7:0] into the TX FIFO, reads 0
//       +0x4 STATUS  [0] full, [1] empty, [2] tx_busy, [3] overflow (sticky,
//                    write 1 to clear), [15:8] FIFO count
//       +0x8 CYCLE   free-running cycle counter, writable
//       +0xC         reads 0, writes ignored
// Anything else reads 0 and ignores writes. Reads are combinational and see
// pre-edge state; writes commit on the rising edge of sysclk.
//
// Ports:
//   sysclk        system clock, rising edge
//   nrst_in       asynchronous active-low reset
//   dmem_rd_addr  read byte address
//   dmem_rd_data  combinational read data
//   dmem_wr_addr  write byte address
//   dmem_wr_data  write data
//   dmem_wr_en    write strobe, one write per asserted cycle
//   uart_tx       8N1 serial output, idle high, registered
// ----------------------------------------------------------------------------
module dmem_mmio_responder #(
  parameter int          RAM_WORDS     = 1024,
  parameter int          TX_FIFO_DEPTH = 8,
  parameter int          CLKS_PER_BIT  = 868,
  parameter logic [31:0] MMIO_BASE     = 32'h1000_0000
) (
  input  logic        sysclk,
  input  logic        nrst_in,
  input  logic [31:0] dmem_rd_addr,
  output logic [31:0] dmem_rd_data,
  input  logic [31:0] dmem_wr_addr,
  input  logic [31:0] dmem_wr_data,
  input  logic        dmem_wr_en,
  output logic        uart_tx
);

  localparam int          RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int          PTR_W     = $clog2(TX_FIFO_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam int          BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Storage (not reset)
  logic [31:0] mem_q  [RAM_WORDS];
  logic [7:0]  fifo_q [TX_FIFO_DEPTH];
  logic [7:0]  shift_q, shift_d;

  // Control state
  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       cyc_q, cyc_d;

  // Address decode
  logic              rd_ram_hit, rd_mmio_hit;
  logic              wr_ram_hit, wr_mmio_hit;
  logic [RAM_AW-1:0] rd_idx, wr_idx;
  logic [1:0]        rd_off, wr_off;

  // The byte lane bits carry no information for word accesses.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{dmem_rd_addr[1:0], dmem_wr_addr[1:0]};

  // RAM takes precedence should a parameterisation ever overlap the regions.
  always_comb begin
    rd_ram_hit  = dmem_rd_addr < RAM_BYTES;
    rd_mmio_hit = !rd_ram_hit && (dmem_rd_addr[31:4] == MMIO_BASE[31:4]);
    wr_ram_hit  = dmem_wr_addr < RAM_BYTES;
    wr_mmio_hit = !wr_ram_hit && (dmem_wr_addr[31:4] == MMIO_BASE[31:4]);
    rd_idx      = dmem_rd_addr[RAM_AW+1:2];
    wr_idx      = dmem_wr_addr[RAM_AW+1:2];
    rd_off      = dmem_rd_addr[3:2];
    wr_off      = dmem_wr_addr[3:2];
  end

  // Write strobes per target
  logic ram_we, push_req, status_we, cycle_we;

  always_comb begin
    ram_we    = dmem_wr_en && wr_ram_hit;
    push_req  = dmem_wr_en && wr_mmio_hit && (wr_off == OFF_TXDATA);
    status_we = dmem_wr_en && wr_mmio_hit && (wr_off == OFF_STATUS);
    cycle_we  = dmem_wr_en && wr_mmio_hit && (wr_off == OFF_CYCLE);
  end

  // FIFO flow control. The UART only pops while IDLE, so a full FIFO can
  // still accept a push in the same cycle the transmitter drains an entry.
  logic fifo_empty, fifo_full, pop, push_ok, tx_busy;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(TX_FIFO_DEPTH));
    tx_busy    = (state_q != ST_IDLE);
    pop        = (state_q == ST_IDLE) && !fifo_empty;
    push_ok    = push_req && (!fifo_full || pop);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
  end

  // Overflow is sticky; a dropped push and a clear cannot share a cycle
  // because only one write is presented per cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (push_req && !push_ok)             ovf_d = 1'b1;
    else if (status_we && dmem_wr_data[3]) ovf_d = 1'b0;
  end

  // A software load of the counter wins over the increment.
  always_comb begin
    cyc_d = cycle_we ? dmem_wr_data : cyc_q + 32'd1;
  end

  // UART transmitter. tx_d is what uart_tx shows after the edge, so every
  // state transition also sets the level of the bit being entered.
  logic baud_done;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          shift_d = fifo_q[rd_ptr_q];
          bit_d   = 3'd0;
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cyc_q    <= cyc_d;
    end
  end

  // Data storage carries no reset; the FIFO pointers define what is valid.
  always_ff @(posedge sysclk) begin
    shift_q <= shift_d;
    if (ram_we)  mem_q[wr_idx]    <= dmem_wr_data;
    if (push_ok) fifo_q[wr_ptr_q] <= dmem_wr_data[7:0];
  end

  // Read mux: all sources are pre-edge state, so a same-cycle write to the
  // address being read is not visible until the next cycle.
  logic [31:0] status_word;

  always_comb begin
    status_word = {16'h0000, 8'(count_q), 4'h0, ovf_q, tx_busy, fifo_empty, fifo_full};
    dmem_rd_data = 32'h0000_0000;
    if (rd_ram_hit) begin
      dmem_rd_data = mem_q[rd_idx];
    end else if (rd_mmio_hit) begin
      case (rd_off)
        OFF_STATUS: dmem_rd_data = status_word;
        OFF_CYCLE:  dmem_rd_data = cyc_q;
        default:    dmem_rd_data = 32'h0000_0000;
      endcase
    end
  end

  assign uart_tx = tx_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_mmio_responder
//
// Self-checking bench for dmem_mmio_responder with a short bit time. A
// reference RAM array, a byte-level UART receiver and frame waveforms built
// from the 8N1 format provide every expected value.
// ----------------------------------------------------------------------------
module tb_dmem_mmio_responder;

  localparam int          CPB       = 4;
  localparam int          DEPTH     = 8;
  localparam int          RAM_WORDS = 256;
  localparam logic [31:0] MMIO      = 32'h1000_0000;
  localparam logic [31:0] A_TXDATA  = MMIO + 32'h0;
  localparam logic [31:0] A_STATUS  = MMIO + 32'h4;
  localparam logic [31:0] A_CYCLE   = MMIO + 32'h8;
  localparam logic [31:0] A_RSVD    = MMIO + 32'hC;

  logic        sysclk;
  logic        nrst_in;
  logic [31:0] dmem_rd_addr;
  logic [31:0] dmem_rd_data;
  logic [31:0] dmem_wr_addr;
  logic [31:0] dmem_wr_data;
  logic        dmem_wr_en;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  dmem_mmio_responder #(
    .RAM_WORDS    (RAM_WORDS),
    .TX_FIFO_DEPTH(DEPTH),
    .CLKS_PER_BIT (CPB),
    .MMIO_BASE    (MMIO)
  ) dut (
    .sysclk      (sysclk),
    .nrst_in     (nrst_in),
    .dmem_rd_addr(dmem_rd_addr),
    .dmem_rd_data(dmem_rd_data),
    .dmem_wr_addr(dmem_wr_addr),
    .dmem_wr_data(dmem_wr_data),
    .dmem_wr_en  (dmem_wr_en),
    .uart_tx     (uart_tx)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // UART receiver: samples mid-bit, discards frames disturbed by reset.
  int          rst_cnt = 0;
  int          frame_err = 0;
  logic [7:0]  rx_q[$];

  always @(negedge nrst_in) rst_cnt++;

  initial begin : uart_rx
    int         start_rst;
    logic [7:0] b;
    logic       ok;
    forever begin
      @(negedge uart_tx);
      start_rst = rst_cnt;
      ok = 1'b1;
      repeat (CPB / 2) @(negedge sysclk);
      if (uart_tx !== 1'b0) ok = 1'b0;
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(negedge sysclk);
        b[j] = uart_tx;
      end
      repeat (CPB) @(negedge sysclk);
      if (uart_tx !== 1'b1) ok = 1'b0;
      if (rst_cnt == start_rst) begin
        if (ok) rx_q.push_back(b);
        else    frame_err++;
      end
    end
  end

  // Stimulus helpers
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    dmem_wr_addr = a;
    dmem_wr_data = d;
    dmem_wr_en   = 1'b1;
    step();
    dmem_wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    dmem_rd_addr = a;
    #1;
    d = dmem_rd_data;
  endtask

  // Expected line level of one 8N1 frame followed by the idle pop cycle.
  task automatic add_frame(inout logic w[$], input logic [7:0] b);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (k == 0)      w.push_back(1'b0);
        else if (k == 9) w.push_back(1'b1);
        else             w.push_back(b[k-1]);
      end
    end
    w.push_back(1'b1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    rd(A_STATUS, s);
    while (!(s[1] && !s[2]) && n < budget) begin
      step();
      rd(A_STATUS, s);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s idle timeout: status=%h required empty and not busy", tag, s);
    end
    repeat (CPB) step();
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    nrst_in = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    rd(A_STATUS, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h want 00000002", d); end
    nrst_in = 1'b1;
    rd(A_CYCLE, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL cycle_first: got %h want 0", d); end
    for (int i = 1; i <= 3; i++) begin
      step();
      rd(A_CYCLE, d);
      checks++;
      if (d !== 32'(i)) begin errors++; $display("FAIL cycle_count: got %h want %h", d, i); end
    end
    rd(A_STATUS, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL post_reset_status: got %h want 00000002", d); end
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL post_reset_tx: got %b want 1", uart_tx); end
  endtask

  task automatic test_ram_collision();
    logic [31:0] d;
    wr(32'h10, 32'hDEAD_BEEF);
    dmem_wr_addr = 32'h10;
    dmem_wr_data = 32'h1234_5678;
    dmem_wr_en   = 1'b1;
    rd(32'h10, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL collision_pre: got %h want deadbeef", d); end
    step();
    dmem_wr_en = 1'b0;
    rd(32'h10, d);
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL collision_post: got %h want 12345678", d); end
    rd(32'h2000_0000, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", d); end
    wr(A_RSVD, 32'hFFFF_FFFF);
    rd(A_RSVD, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h want 0", d); end
    rd(A_TXDATA, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h want 0", d); end
  endtask

  task automatic test_ram_random();
    logic [31:0] ram_m [RAM_WORDS];
    logic [31:0] d, exp, ra, wa, wd;
    int          kind;
    for (int i = 0; i < RAM_WORDS; i++) begin
      ram_m[i] = $urandom;
      wr(32'(i * 4), ram_m[i]);
    end
    for (int n = 0; n < 300; n++) begin
      // read side
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1, 2: ra = 32'($urandom_range(0, RAM_WORDS - 1) * 4 + $urandom_range(0, 3));
        3:       ra = 32'h2000_0000 + ($urandom & 32'hFFFF);
        default: ra = ($urandom_range(0, 1) == 0) ? 32'(RAM_WORDS * 4) + ($urandom & 32'hFFFC)
                                                  : MMIO + 32'h10 + ($urandom & 32'hFFC);
      endcase
      exp = (ra < 32'(RAM_WORDS * 4)) ? ram_m[ra >> 2] : 32'h0;
      // write side, sometimes aimed at the word being read
      kind = $urandom_range(0, 5);
      wd = $urandom;
      case (kind)
        0:       wa = ra;
        1, 2:    wa = 32'($urandom_range(0, RAM_WORDS - 1) * 4 + $urandom_range(0, 3));
        3:       wa = 32'h2000_0000 + ($urandom & 32'hFFFC);
        4:       wa = A_RSVD;
        default: wa = 32'(RAM_WORDS * 4) + ($urandom & 32'hFFFC);
      endcase
      dmem_wr_addr = wa;
      dmem_wr_data = wd;
      dmem_wr_en   = ($urandom_range(0, 3) != 0);
      rd(ra, d);
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL ram_random: addr=%h got %h want %h", ra, d, exp);
      end
      if (dmem_wr_en && wa < 32'(RAM_WORDS * 4)) ram_m[wa >> 2] = wd;
      step();
      dmem_wr_en = 1'b0;
    end
  endtask

  task automatic test_cycle();
    logic [31:0] d, v;
    logic [31:0] seq [3];
    seq[0] = 32'hFFFF_FFFE;
    seq[1] = 32'hFFFF_FFFF;
    seq[2] = 32'h0000_0000;
    wr(A_CYCLE, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      rd(A_CYCLE, d);
      checks++;
      if (d !== seq[i]) begin errors++; $display("FAIL cycle_wrap: got %h want %h", d, seq[i]); end
    end
    v = $urandom;
    wr(A_CYCLE, v);
    repeat (5) step();
    rd(A_CYCLE, d);
    checks++;
    if (d !== v + 32'd5) begin errors++; $display("FAIL cycle_load: got %h want %h", d, v + 32'd5); end
  endtask

  task automatic test_uart_frame();
    logic        w[$];
    logic [31:0] s;
    add_frame(w, 8'h55);
    rx_q.delete();
    wr(A_TXDATA, 32'h55);
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL frame_lat: tx=%b want 1 at write edge", uart_tx); end
    for (int i = 0; i < 10 * CPB; i++) begin
      step();
      rd(A_STATUS, s);
      checks++;
      if (uart_tx !== w[i] || s[2] !== 1'b1) begin
        errors++;
        $display("FAIL frame_55 cyc %0d: tx=%b busy=%b want tx=%b busy=1", i, uart_tx, s[2], w[i]);
      end
    end
    step();
    rd(A_STATUS, s);
    checks++;
    if (uart_tx !== 1'b1 || s !== 32'h2) begin
      errors++;
      $display("FAIL frame_end: tx=%b status=%h want tx=1 status=00000002", uart_tx, s);
    end
    wait_idle(100, "frame");
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55 || frame_err != 0) begin
      errors++;
      $display("FAIL frame_rx: count=%0d ferr=%0d want one byte 55", rx_q.size(), frame_err);
    end
  endtask

  task automatic test_back_to_back();
    logic       w[$];
    logic [7:0] b0, b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    add_frame(w, b0);
    add_frame(w, b1);
    rx_q.delete();
    wr(A_TXDATA, {24'h0, b0});
    wr(A_TXDATA, {24'h0, b1});
    for (int i = 0; i < w.size(); i++) begin
      if (i > 0) step();
      checks++;
      if (uart_tx !== w[i]) begin
        errors++;
        $display("FAIL b2b cyc %0d: tx=%b want %b", i, uart_tx, w[i]);
      end
    end
    wait_idle(200, "b2b");
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== b0 || rx_q[1] !== b1) begin
      errors++;
      $display("FAIL b2b_rx: count=%0d want 2 bytes %h %h", rx_q.size(), b0, b1);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    logic        ok;
    rx_q.delete();
    for (int i = 0; i < 10; i++) wr(A_TXDATA, 32'(i));
    rd(A_STATUS, s);
    checks++;
    if (s !== 32'h0000_080D) begin errors++; $display("FAIL ovf_status: got %h want 0000080d", s); end
    wr(A_STATUS, 32'h8);
    rd(A_STATUS, s);
    checks++;
    if (s !== 32'h0000_0805) begin errors++; $display("FAIL ovf_clear: got %h want 00000805", s); end
    wait_idle(1000, "ovf");
    ok = (rx_q.size() == 9) && (frame_err == 0);
    for (int i = 0; i < rx_q.size() && i < 9; i++) if (rx_q[i] !== 8'(i)) ok = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_rx: count=%0d ferr=%0d want bytes 00..08", rx_q.size(), frame_err); end
  endtask

  task automatic test_random_bytes();
    logic [7:0] exp_q[$];
    logic       ok;
    int         nb;
    for (int r = 0; r < 3; r++) begin
      rx_q.delete();
      exp_q.delete();
      nb = $urandom_range(1, DEPTH - 2);
      for (int i = 0; i < nb; i++) begin
        exp_q.push_back(8'($urandom));
        wr(A_TXDATA, {24'h0, exp_q[i]});
        repeat ($urandom_range(0, 3 * CPB)) step();
      end
      wait_idle(1000, "rand");
      ok = (rx_q.size() == exp_q.size()) && (frame_err == 0);
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_rx round %0d: got %0d bytes want %0d", r, rx_q.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] s;
    logic        stayed_high;
    rx_q.delete();
    for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'hA0 + 32'(i));
    repeat (3 * CPB) step();
    nrst_in = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b want 1", uart_tx); end
    rd(A_STATUS, s);
    checks++;
    if (s !== 32'h2) begin errors++; $display("FAIL midreset_status: got %h want 00000002", s); end
    step();
    nrst_in = 1'b1;
    stayed_high = 1'b1;
    for (int i = 0; i < 30 * CPB; i++) begin
      step();
      if (uart_tx !== 1'b1) stayed_high = 1'b0;
    end
    checks++;
    if (!stayed_high) begin errors++; $display("FAIL midreset_quiet: tx left idle, want high"); end
    rd(A_STATUS, s);
    checks++;
    if (s !== 32'h2 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_after: status=%h frames=%0d want 00000002 and 0", s, rx_q.size());
    end
  endtask

  initial begin
    nrst_in      = 1'b0;
    dmem_rd_addr = 32'h0;
    dmem_wr_addr = 32'h0;
    dmem_wr_data = 32'h0;
    dmem_wr_en   = 1'b0;
    test_reset();
    test_ram_collision();
    test_ram_random();
    test_cycle();
    test_uart_frame();
    test_back_to_back();
    test_overflow();
    test_random_bytes();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
